// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: keeps one imem request in flight, holds the
// returned word for decode, and applies execute-stage redirects with squash.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] instr_pc_q, instr_pc_n;
    logic        squash, squash_n;
    logic        err, err_n;
    logic [31:0] target;
    logic        taken;

    always_comb begin
        target = branch_target;
        case (pc_src)
            2'b01:   target = branch_target;
            2'b10:   target = jal_target;
            2'b11:   target = {jalr_target[31:1], 1'b0};
            default: target = branch_target;
        endcase
    end

    // Redirects only matter once fetching is underway and before a halt.
    assign taken = redirect_valid && (pc_src != 2'b00) &&
                   (state == REQ || state == WAIT || state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            squash     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            squash     <= squash_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        squash_n   = squash;
        err_n      = err;

        case (state)
            IDLE: state_n = REQ;
            REQ:  if (imem_req_ready) state_n = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (squash) begin
                        squash_n = 1'b0;
                        state_n  = REQ;
                    end else begin
                        instr_n    = imem_rsp_data;
                        instr_pc_n = pc;
                        pc_n       = pc + 32'd4;
                        state_n    = HOLD;
                    end
                end
            end
            HOLD: if (!stall) state_n = REQ;
            HALT: state_n = HALT;
            default: state_n = IDLE;
        endcase

        if (taken) begin
            instr_n    = instr_q;
            instr_pc_n = instr_pc_q;
            if (target[1:0] != 2'b00) begin
                err_n    = 1'b1;
                squash_n = 1'b0;
                pc_n     = pc;
                state_n  = HALT;
            end else begin
                pc_n     = target;
                squash_n = 1'b0;
                state_n  = REQ;
                // A request is (or becomes) in flight without its response yet:
                // wait it out and throw the word away. A response landing in
                // this same cycle is simply dropped.
                if ((state == REQ && imem_req_ready) ||
                    (state == WAIT && !imem_rsp_valid)) begin
                    squash_n = 1'b1;
                    state_n  = WAIT;
                end
            end
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign instr_valid    = (state == HOLD);
    assign instr          = instr_valid ? instr_q : NOP_INSTR;
    assign instr_pc       = instr_pc_q;
    assign pc_plus4       = pc + 32'd4;
    assign misalign_err   = err;

endmodule
